// File: rtl/pwm_gen_pkg.sv
// Shared constants, duty-update opcode and width helper for the push-button PWM generator.
package pwm_gen_pkg;

  localparam int unsigned PWM_PERIOD_DEF    = 10;
  localparam int unsigned PWM_DUTY_INIT_DEF = 5;
  localparam int unsigned PWM_SLOW_DIV_DEF  = 4;

  typedef enum logic [1:0] {
    DUTY_HOLD = 2'd0,
    DUTY_INC  = 2'd1,
    DUTY_DEC  = 2'd2
  } duty_op_e;

  // Bits needed to hold any duty level 0..period inclusive.
  function automatic int unsigned duty_width(input int unsigned period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Two-stage button sampler producing one clk-wide pulse per press.
module pwm_btn_debounce
  import pwm_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic slow_en,
  input  logic btn,
  output logic press_pulse
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else if (slow_en) begin
      s0_q <= btn;
      s1_q <= s0_q;
    end
  end

  // Rising edge of the sampled button, qualified so it lasts exactly one clk.
  assign press_pulse = s0_q & ~s1_q & slow_en;

endmodule

// File: rtl/pwm_generator_verilog.sv
// Fixed-period PWM whose duty is stepped up/down by two push buttons.
// Define PWM_DEBOUNCE_EN to sample the buttons through the slow-enable divider.
module pwm_generator_verilog
  import pwm_gen_pkg::*;
#(
  parameter int unsigned PERIOD    = PWM_PERIOD_DEF,
  parameter int unsigned DUTY_INIT = PWM_DUTY_INIT_DEF,
  parameter int unsigned SLOW_DIV  = PWM_SLOW_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
);

  localparam int unsigned DUTY_W = duty_width(PERIOD);

  logic slow_en;

`ifdef PWM_DEBOUNCE_EN
  localparam int unsigned DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    slow_en   = (div_cnt_q == DIV_W'(SLOW_DIV - 1));
    div_cnt_d = slow_en ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end
`else
  // Every clk is a sample point; SLOW_DIV is only meaningful with the divider.
  assign slow_en = (SLOW_DIV != 0);
`endif

  logic inc_pulse;
  logic dec_pulse;

  pwm_btn_debounce u_inc_btn (
    .clk         (clk),
    .rst         (rst),
    .slow_en     (slow_en),
    .btn         (increase_duty),
    .press_pulse (inc_pulse)
  );

  pwm_btn_debounce u_dec_btn (
    .clk         (clk),
    .rst         (rst),
    .slow_en     (slow_en),
    .btn         (decrease_duty),
    .press_pulse (dec_pulse)
  );

  duty_op_e          duty_op;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] cnt_d;
  logic              pwm_q;
  logic              pwm_d;

  // Simultaneous presses cancel out; saturate at both ends.
  always_comb begin
    duty_op = DUTY_HOLD;
    if (inc_pulse && !dec_pulse) begin
      duty_op = DUTY_INC;
    end else if (dec_pulse && !inc_pulse) begin
      duty_op = DUTY_DEC;
    end

    duty_d = duty_q;
    case (duty_op)
      DUTY_INC: if (duty_q < DUTY_W'(PERIOD)) duty_d = duty_q + 1'b1;
      DUTY_DEC: if (duty_q != '0)             duty_d = duty_q - 1'b1;
      default:  duty_d = duty_q;
    endcase
  end

  always_comb begin
    cnt_d = (cnt_q == DUTY_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    pwm_d = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= DUTY_W'(DUTY_INIT);
      cnt_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
    end
  end

  assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_generator_verilog.sv
// Self-checking bench for pwm_generator_verilog: duty tracked by a saturating model, measured as high-count per window.
module tb_pwm_generator_verilog;

  localparam int unsigned PERIOD    = 10;
  localparam int unsigned DUTY_INIT = 5;
  localparam int unsigned SLOW_DIV  = 4;
  localparam int unsigned GAP       = 3 * SLOW_DIV + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inc = 1'b0;
  logic dec = 1'b0;
  logic pwm_out;

  int errors = 0;
  int checks = 0;
  int m_duty = int'(DUTY_INIT);
  int edges;

  pwm_generator_verilog #(
    .PERIOD    (PERIOD),
    .DUTY_INIT (DUTY_INIT),
    .SLOW_DIV  (SLOW_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .increase_duty (inc),
    .decrease_duty (dec),
    .PWM_OUT       (pwm_out)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release, used to place glitches between sample points.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic int model_step(input int d, input bit up, input bit dn);
    if (up && !dn) return (d < int'(PERIOD)) ? d + 1 : d;
    if (dn && !up) return (d > 0) ? d - 1 : d;
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    inc = 1'b0;
    dec = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_duty = int'(DUTY_INIT);
  endtask

  task automatic press(input bit up, input bit dn, input int len);
    inc = up;
    dec = dn;
    repeat (len) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (GAP) @(negedge clk);
    m_duty = model_step(m_duty, up, dn);
  endtask

  task automatic measure(output int highs);
    highs = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
  endtask

  task automatic test_reset();
    int exp_bit;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_low: PWM_OUT=%b expected 0", pwm_out);
      end
    end
    rst = 1'b0;
    m_duty = int'(DUTY_INIT);
    for (int k = 1; k <= 2 * int'(PERIOD); k++) begin
      @(negedge clk);
      exp_bit = (((k - 1) % int'(PERIOD)) < int'(DUTY_INIT)) ? 1 : 0;
      checks++;
      if (pwm_out !== 1'(exp_bit)) begin
        errors++;
        $display("FAIL reset_wave cycle %0d: PWM_OUT=%b expected %0d", k, pwm_out, exp_bit);
      end
    end
  endtask

  task automatic test_increase();
    int highs;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 10);
      if (i == 0 || i == 2) begin
        measure(highs);
        checks++;
        if (highs != 2 * m_duty) begin
          errors++;
          $display("FAIL increase_%0d: high=%0d expected %0d", i, highs, 2 * m_duty);
        end
      end
    end
  endtask

  task automatic test_decrease();
    int highs;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, 10);
      measure(highs);
      checks++;
      if (highs != 2 * m_duty) begin
        errors++;
        $display("FAIL decrease_%0d: high=%0d expected %0d", i, highs, 2 * m_duty);
      end
    end
  endtask

  task automatic test_saturate();
    int highs;
    do_reset();
    repeat (6) press(1'b1, 1'b0, 10);
    measure(highs);
    checks++;
    if (highs != 2 * int'(PERIOD) || m_duty != int'(PERIOD)) begin
      errors++;
      $display("FAIL saturate_high: high=%0d expected %0d", highs, 2 * PERIOD);
    end
    repeat (11) press(1'b0, 1'b1, 10);
    measure(highs);
    checks++;
    if (highs != 0 || m_duty != 0) begin
      errors++;
      $display("FAIL saturate_low: high=%0d expected 0", highs);
    end
  endtask

  task automatic test_both();
    int highs;
    do_reset();
    press(1'b1, 1'b1, 10);
    measure(highs);
    checks++;
    if (highs != 2 * int'(DUTY_INIT)) begin
      errors++;
      $display("FAIL both_pressed: high=%0d expected %0d", highs, 2 * DUTY_INIT);
    end
  endtask

  task automatic test_reset_mid();
    int highs;
    int guard;
    do_reset();
    repeat (3) press(1'b1, 1'b0, 10);
    measure(highs);
    checks++;
    if (highs != 2 * m_duty) begin
      errors++;
      $display("FAIL mid_pre_duty: high=%0d expected %0d", highs, 2 * m_duty);
    end
    guard = 0;
    while (pwm_out !== 1'b1 && guard < 2 * int'(PERIOD)) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: PWM_OUT=%b expected 0", pwm_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_duty = int'(DUTY_INIT);
    repeat (2) @(negedge clk);
    measure(highs);
    checks++;
    if (highs != 2 * int'(DUTY_INIT)) begin
      errors++;
      $display("FAIL mid_reset_resume: high=%0d expected %0d", highs, 2 * DUTY_INIT);
    end
  endtask

  task automatic test_glitch();
    int highs;
    int exp_duty;
    do_reset();
    while ((edges % int'(SLOW_DIV)) != 0) @(negedge clk);
    inc = 1'b1;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    repeat (GAP) @(negedge clk);
`ifdef PWM_DEBOUNCE_EN
    exp_duty = int'(DUTY_INIT);
`else
    exp_duty = int'(DUTY_INIT) + 1;
`endif
    m_duty = exp_duty;
    measure(highs);
    checks++;
    if (highs != 2 * exp_duty) begin
      errors++;
      $display("FAIL glitch: high=%0d expected %0d", highs, 2 * exp_duty);
    end
  endtask

  task automatic test_random();
    int highs;
    int kind;
    int len;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(2 * SLOW_DIV, 3 * SLOW_DIV));
      press(kind == 0 || kind == 2, kind == 1 || kind == 2, len);
      measure(highs);
      checks++;
      if (highs != 2 * m_duty) begin
        errors++;
        $display("FAIL random_%0d kind=%0d: high=%0d expected %0d", i, kind, highs, 2 * m_duty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_increase();
    test_decrease();
    test_saturate();
    test_both();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
